bus_timer: RTL and testbench
============================

Name: bus_timer

Overview:
- Memory-mapped countdown timer. It is the responder side of the data-memory bus that the MEM stage drives (word address, byte write-enables, write data, read data).
- The system bridge instantiates one copy at Timer0 (0x0000_7F00–0x0000_7F0B) and one at Timer1 (0x0000_7F10–0x0000_7F1B).
- Its IRQ feeds a CP0 hardware-interrupt line: Timer0 drives HWInt[2], Timer1 drives HWInt[3].
- Supports one-shot and auto-reload modes.

Parameters:
CNT_W, 32, width of PRESET and COUNT registers (1..32)

Ports:
clk    input   1      system clock
rst    input   1      synchronous reset, active-high
sel    input   1      bridge address-decode hit for this timer
Addr   input   2      word offset within the timer (CPU address bits [3:2])
WE     input   4      byte write-enables from the MEM stage
WData  input   32     write data
RData  output  32     read data (combinational)
IRQ    output  1      interrupt request to CP0

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, rst).
- Registers, selected by Addr:
  - 0 = CTRL: bit3 IM (irq mask), bits2:1 Mode, bit0 Enable; other bits read 0.
  - 1 = PRESET.
  - 2 = COUNT, read-only.
  - 3 = reserved, reads 0.
- Reset (rst=1 at any edge, including mid-count): CTRL=0, PRESET=0, COUNT=0, state=IDLE, pend=0. RData reflects the reset values; IRQ=0 from the next cycle on.
- Write acceptance:
  - A write occurs only when sel=1 and WE==4'b1111. Partial-byte writes are ignored; the CPU flags them as exceptions.
  - Writes to COUNT or the reserved slot are ignored.
  - PRESET takes WData[CNT_W-1:0]. CTRL takes WData[3:0].
  - Any accepted write to CTRL or PRESET clears pend.
- Read: RData = sel ? selected register, zero-extended : 0. Combinational, zero-cycle latency.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if Enable → LOAD. COUNT holds.
  - LOAD: COUNT←PRESET → CNT.
  - CNT:
    - if !Enable → IDLE (COUNT frozen);
    - else if COUNT>1 → COUNT←COUNT−1;
    - else (COUNT is 1 or 0) → COUNT←0, pend←1, go to INT.
  - INT, Mode==01 (auto-reload): COUNT←PRESET, pend←0 → CNT.
  - INT, any other Mode (00 one-shot; 10/11 reserved, treated as 00): Enable←0 → IDLE. pend stays 1 until CPU clears it by writing CTRL or PRESET.
- IRQ = IM & pend.
  - Auto-reload: IRQ is a 1-cycle pulse per period.
  - One-shot: IRQ is a level.
- Timing, PRESET=N≥1, Enable written at edge E0:
  - E1: LOAD.
  - E2: COUNT=N.
  - E(N+2): state INT, pend=1.
  - Auto-reload period thereafter: N+1 cycles.
  - PRESET=0 behaves as PRESET=1.
- Simultaneous events:
  - Bus write to CTRL at the same edge the FSM clears Enable in INT: the bus value wins.
  - Bus write clearing pend at the edge pend would be set: set wins.
  - Writing PRESET while counting does not disturb COUNT; the new value is used at the next LOAD or reload.
  - Writing Enable=0 then 1 restarts from PRESET.
- No wrap-around: COUNT never decrements below 0.

Test Plan:
- Reset then read all offsets (sel=1, Addr 0..3) → RData=0 each; IRQ=0.
- PRESET=5, then CTRL=0x9 (IM=1, one-shot, enable) at edge E0 → COUNT reads 5 after E2, 4 after E3 … 0 after E7; IRQ=1 from E7 and held; CTRL reads 0x8; write CTRL=0 → IRQ=0 next cycle.
- PRESET=3, CTRL=0xB (auto-reload) → IRQ pulses high exactly 1 cycle, every 4 cycles; COUNT sequence 3,2,1,0,3,2,…; IM=0 variant → IRQ never asserts while COUNT still cycles.
- Mid-count: PRESET=10, enable, write CTRL Enable=0 when COUNT=6 → COUNT frozen at 6/5 per edge alignment; re-enable → COUNT reloads to 10 two edges later.
- Write COUNT=0x1234 and a PRESET write with WE=4'b0011 → both ignored; assert rst during CNT → next cycle COUNT=0, CTRL=0, IRQ=0, state IDLE.
- In INT (one-shot), bus writes CTRL=0x1 at the same edge → Enable remains 1, pend cleared, counting restarts via LOAD.

Source files
------------

// File: rtl/bus_timer_if.sv
// Data-memory bus as seen by a memory-mapped responder.
//   sel   : bridge address-decode hit
//   Addr  : word offset within the responder (CPU address bits [3:2])
//   WE    : byte write-enables
//   WData : write data
//   RData : read data, driven combinationally by the responder
interface bus_timer_if;
  logic        sel;
  logic [1:0]  Addr;
  logic [3:0]  WE;
  logic [31:0] WData;
  logic [31:0] RData;

  modport master (output sel, output Addr, output WE, output WData, input RData);
  modport slave  (input sel, input Addr, input WE, input WData, output RData);
endinterface

// File: rtl/bus_timer.sv
// Memory-mapped countdown timer with one-shot and auto-reload modes.
// Ports:
//   clk  : system clock
//   rst  : synchronous reset, active-high
//   bus  : data-memory bus, responder side (sel, Addr, WE, WData -> RData)
//   IRQ  : interrupt request, IM & pend
// Register map (word offset):
//   0 CTRL   {IM, Mode[1:0], Enable} in bits 3:0
//   1 PRESET reload value
//   2 COUNT  current count, read-only
//   3 reserved, reads 0
//
// state | meaning
// IDLE  | stopped, COUNT holds, waits for Enable
// LOAD  | COUNT <- PRESET on the next edge
// CNT   | counting down towards 0
// INT   | terminal count reached, pend set; reload or stop
module bus_timer #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  bus_timer_if.slave  bus,
  output logic        IRQ
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_q;
  logic [3:0]       ctrl_q;
  logic [CNT_W-1:0] preset_q;
  logic [CNT_W-1:0] count_q;
  logic             pend_q;

  logic             wr_d;
  logic             wr_ctrl_d;
  logic             wr_pre_d;
  logic [31:0]      preset_ext_d;
  logic [31:0]      count_ext_d;

  // Only full-word writes are accepted; partial writes trap in the CPU.
  assign wr_d      = bus.sel && (bus.WE == 4'b1111);
  assign wr_ctrl_d = wr_d && (bus.Addr == 2'd0);
  assign wr_pre_d  = wr_d && (bus.Addr == 2'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ctrl_q   <= 4'b0;
      preset_q <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
    end else begin
      // Bus side first so that a pend set by the FSM below overrides a
      // clearing write on the same edge.
      if (wr_ctrl_d) ctrl_q <= bus.WData[3:0];
      if (wr_pre_d)  preset_q <= bus.WData[CNT_W-1:0];
      if (wr_ctrl_d || wr_pre_d) pend_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (ctrl_q[0]) state_q <= LOAD;
        end
        LOAD: begin
          count_q <= preset_q;
          state_q <= CNT;
        end
        CNT: begin
          if (!ctrl_q[0]) begin
            state_q <= IDLE;
          end else if (count_q > ONE) begin
            count_q <= count_q - ONE;
          end else begin
            // COUNT of 0 (PRESET=0) terminates like COUNT of 1.
            count_q <= '0;
            pend_q  <= 1'b1;
            state_q <= INT;
          end
        end
        INT: begin
          if (ctrl_q[2:1] == 2'b01) begin
            count_q <= preset_q;
            pend_q  <= 1'b0;
            state_q <= CNT;
          end else begin
            // A CTRL write landing on this edge keeps its own Enable.
            if (!wr_ctrl_d) ctrl_q[0] <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign IRQ = ctrl_q[3] & pend_q;

  always_comb begin
    preset_ext_d = '0;
    count_ext_d  = '0;
    preset_ext_d[CNT_W-1:0] = preset_q;
    count_ext_d[CNT_W-1:0]  = count_q;
  end

  always_comb begin
    bus.RData = 32'b0;
    if (bus.sel) begin
      case (bus.Addr)
        2'd0:    bus.RData = {28'b0, ctrl_q};
        2'd1:    bus.RData = preset_ext_d;
        2'd2:    bus.RData = count_ext_d;
        default: bus.RData = 32'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_timer.sv
module tb_bus_timer;

  logic clk;
  logic rst;
  logic IRQ;

  bus_timer_if bus_if ();

  bus_timer #(.CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if),
    .IRQ (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model. A run is tracked by its age (edges since the timer
  // left the stopped condition, -1 when stopped) and the PRESET latched at
  // load time; COUNT and the terminal event are derived arithmetically.
  // ---------------------------------------------------------------------
  logic [3:0]  m_ctrl;
  logic [31:0] m_pre;
  logic [31:0] m_praw;
  logic [31:0] m_cnt;
  logic        m_pend;
  int          m_age;

  function automatic longint eff_p(input logic [31:0] praw);
    return (praw == 32'd0) ? 64'd1 : longint'(praw);
  endfunction

  function automatic logic [31:0] m_count();
    longint p;
    p = eff_p(m_praw);
    if (m_age < 2) return m_cnt;
    if (longint'(m_age) <= p + 1) return m_praw - 32'(m_age - 2);
    return 32'd0;
  endfunction

  logic [31:0] mc_cur;
  logic [3:0]  mc_nctrl;
  logic        mc_set, mc_fclr, mc_wctrl, mc_wpre;
  longint      mc_p;

  always @(posedge clk) begin
    if (rst) begin
      m_ctrl = 4'b0; m_pre = 0; m_praw = 0; m_cnt = 0; m_pend = 1'b0; m_age = -1;
    end else begin
      mc_p     = eff_p(m_praw);
      mc_cur   = m_count();
      mc_set   = 1'b0;
      mc_fclr  = 1'b0;
      mc_nctrl = m_ctrl;
      mc_wctrl = bus_if.sel && bus_if.WE == 4'hF && bus_if.Addr == 2'd0;
      mc_wpre  = bus_if.sel && bus_if.WE == 4'hF && bus_if.Addr == 2'd1;
      if (m_age < 0) begin
        if (m_ctrl[0]) m_age = 1;
      end else if (m_age == 1) begin
        m_age = 2; m_praw = m_pre;
      end else if (longint'(m_age) <= mc_p + 1) begin
        if (!m_ctrl[0]) begin
          m_cnt = mc_cur; m_age = -1;
        end else if (longint'(m_age) == mc_p + 1) begin
          m_age = m_age + 1; mc_set = 1'b1;
        end else begin
          m_age = m_age + 1;
        end
      end else begin
        if (m_ctrl[2:1] == 2'b01) begin
          m_age = 2; m_praw = m_pre; mc_fclr = 1'b1;
        end else begin
          mc_nctrl[0] = 1'b0; m_cnt = 32'd0; m_age = -1;
        end
      end
      if (mc_wctrl) mc_nctrl = bus_if.WData[3:0];
      if (mc_wpre)  m_pre = bus_if.WData;
      m_ctrl = mc_nctrl;
      if (mc_set) m_pend = 1'b1;
      else if (mc_wctrl || mc_wpre || mc_fclr) m_pend = 1'b0;
    end
  end

  logic [31:0] exp_rd;
  always @(negedge clk) begin
    if (chk_en) begin
      exp_rd = 32'd0;
      if (bus_if.sel) begin
        case (bus_if.Addr)
          2'd0: exp_rd = {28'd0, m_ctrl};
          2'd1: exp_rd = m_pre;
          2'd2: exp_rd = m_count();
          default: exp_rd = 32'd0;
        endcase
      end
      check("model_rdata", bus_if.RData, exp_rd);
      check("model_irq", {31'd0, IRQ}, {31'd0, m_ctrl[3] & m_pend});
    end
  end

  // ---------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // ---------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus_if.sel = 1'b1; bus_if.Addr = 2'd2; bus_if.WE = 4'h0; bus_if.WData = 32'd0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] we);
    bus_if.sel = 1'b1; bus_if.Addr = a; bus_if.WE = we; bus_if.WData = d;
    tick();
    idle_bus();
  endtask

  task automatic rd_lit(input string name, input logic [1:0] a, input logic [31:0] exp);
    bus_if.Addr = a;
    #1;
    check(name, bus_if.RData, exp);
    bus_if.Addr = 2'd2;
  endtask

  task automatic irq_lit(input string name, input logic exp);
    check(name, {31'd0, IRQ}, {31'd0, exp});
  endtask

  int irq_seen;
  logic [31:0] exp_c;

  initial begin
    rst = 1'b1;
    bus_if.sel = 1'b0; bus_if.Addr = 2'd0; bus_if.WE = 4'h0; bus_if.WData = 32'd0;
    tick(); tick();
    chk_en = 1'b1;
    rst = 1'b0;
    idle_bus();
    for (int a = 0; a < 4; a++) rd_lit("reset_read", 2'(a), 32'd0);
    irq_lit("reset_irq", 1'b0);

    // One-shot, PRESET=5
    bus_write(2'd1, 32'd5, 4'hF);
    bus_write(2'd0, 32'h9, 4'hF);          // E0
    tick();                                // E1
    rd_lit("os_load_hold", 2'd2, 32'd0);
    for (int k = 2; k <= 7; k++) begin
      tick();
      rd_lit("os_count", 2'd2, 32'(7 - k));
    end
    irq_lit("os_irq_e7", 1'b1);
    tick();                                // E8
    rd_lit("os_ctrl_after", 2'd0, 32'h8);
    irq_lit("os_irq_held", 1'b1);
    bus_write(2'd0, 32'h0, 4'hF);
    irq_lit("os_irq_cleared", 1'b0);

    // Auto-reload, PRESET=3
    bus_write(2'd1, 32'd3, 4'hF);
    bus_write(2'd0, 32'hB, 4'hF);          // E0
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (k < 2) exp_c = 32'd0;
      else exp_c = (((k - 2) % 4) < 3) ? 32'(3 - ((k - 2) % 4)) : 32'd0;
      rd_lit("ar_count", 2'd2, exp_c);
      irq_lit("ar_irq", (k >= 5) && (((k - 5) % 4) == 0));
    end
    bus_write(2'd0, 32'h3, 4'hF);          // IM=0, still auto-reload
    irq_seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (IRQ) irq_seen++;
    end
    check("ar_masked_irq_count", 32'(irq_seen), 32'd0);
    bus_write(2'd0, 32'h0, 4'hF);
    tick(); tick();

    // Mid-count disable and restart, PRESET=10
    bus_write(2'd1, 32'd10, 4'hF);
    bus_write(2'd0, 32'h1, 4'hF);          // E0
    repeat (6) tick();                     // E6
    rd_lit("mid_count6", 2'd2, 32'd6);
    bus_write(2'd0, 32'h0, 4'hF);          // E7
    rd_lit("mid_last_dec", 2'd2, 32'd5);
    tick(); tick();                        // E9
    rd_lit("mid_frozen", 2'd2, 32'd5);
    bus_write(2'd0, 32'h1, 4'hF);          // F0
    tick();                                // F1
    rd_lit("mid_reload_wait", 2'd2, 32'd5);
    tick();                                // F2
    rd_lit("mid_reloaded", 2'd2, 32'd10);

    // Ignored writes, then reset mid-count
    bus_write(2'd2, 32'h1234, 4'hF);
    bus_write(2'd1, 32'h77, 4'b0011);
    rd_lit("partial_preset", 2'd1, 32'd10);
    rst = 1'b1;
    tick();
    rd_lit("rst_ctrl", 2'd0, 32'd0);
    rd_lit("rst_count", 2'd2, 32'd0);
    irq_lit("rst_irq", 1'b0);
    rst = 1'b0;
    tick();
    rd_lit("rst_stays_idle", 2'd2, 32'd0);

    // Same-edge CTRL write in INT, then pend set vs clear on one edge
    bus_write(2'd1, 32'd2, 4'hF);
    bus_write(2'd0, 32'h9, 4'hF);          // E0
    repeat (4) tick();                     // E4
    irq_lit("int_irq_e4", 1'b1);
    bus_write(2'd0, 32'h9, 4'hF);          // E5
    irq_lit("int_pend_cleared", 1'b0);
    rd_lit("int_enable_kept", 2'd0, 32'h9);
    tick(); tick();                        // E7
    rd_lit("int_restart_count", 2'd2, 32'd2);
    tick();                                // E8
    bus_write(2'd1, 32'd2, 4'hF);          // E9
    irq_lit("set_wins", 1'b1);
    tick();                                // E10
    rd_lit("os_stop_ctrl", 2'd0, 32'h8);
    irq_lit("set_wins_held", 1'b1);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout, expected completion");
    $fatal(1);
  end

endmodule
